// File: rtl/reg_bank_pkg.sv
// ----------------------------------------------------------------------------
// reg_bank_pkg
// Shared types and constants for the register bank unit.
//   src_e        : write-port source select encoding
//   ldr_state_e  : serial nibble loader state encoding
//   NIB_W        : nibble width in bits
// ----------------------------------------------------------------------------
package reg_bank_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        SRC_MEM  = 2'd0,
        SRC_IN   = 2'd1,
        SRC_ALU  = 2'd2,
        SRC_SIGN = 2'd3
    } src_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } ldr_state_e;

endpackage

// File: rtl/reg_bank_unit_nib_loader.sv
// ----------------------------------------------------------------------------
// nib_loader
// Handshaked serial loader: assembles one register from a stream of nibbles,
// least-significant nibble first. It does not own any register storage; it
// hands a one-hot lane mask, the replicated nibble and the captured target
// address to the register array in the top level.
// Ports:
//   ck, rst        clock, synchronous active-high reset
//   i_start        start a load (only honoured in IDLE)
//   i_addr         target register, captured on start
//   i_data         nibble payload
//   i_valid        nibble valid
//   o_ready        registered; high only in LOAD
//   o_done         registered; one-cycle pulse in DONE
//   o_tgt_addr     captured target register
//   o_lane_we      one-hot nibble lane written by the current beat (0 if none)
//   o_lane_data    nibble replicated across the full width
// ----------------------------------------------------------------------------
module nib_loader
    import reg_bank_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NREGS = 4,
    localparam int AW    = $clog2(NREGS),
    localparam int NNIB  = WIDTH / NIB_W
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              i_start,
    input  logic [AW-1:0]     i_addr,
    input  logic [NIB_W-1:0]  i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_done,
    output logic [AW-1:0]     o_tgt_addr,
    output logic [NNIB-1:0]   o_lane_we,
    output logic [WIDTH-1:0]  o_lane_data
);

    localparam int CW = (NNIB > 1) ? $clog2(NNIB) : 1;

    ldr_state_e     r_state;
    logic [CW-1:0]  r_cnt;
    logic [AW-1:0]  r_addr;
    logic           r_ready;
    logic           r_done;
    logic           w_beat;

    // r_ready is high exactly while in LOAD, so it doubles as the state qualifier.
    assign w_beat = r_ready & i_valid;

    always_ff @(posedge ck) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_ready <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_addr  <= i_addr;
                        r_cnt   <= '0;
                        r_ready <= 1'b1;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    if (i_valid) begin
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == CW'(NNIB - 1)) begin
                            r_ready <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_ready <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        o_lane_we = '0;
        for (int k = 0; k < NNIB; k++) begin
            if (w_beat && (r_cnt == CW'(k))) o_lane_we[k] = 1'b1;
        end
    end

    assign o_lane_data = {NNIB{i_data}};
    assign o_tgt_addr  = r_addr;
    assign o_ready     = r_ready;
    assign o_done      = r_done;

endmodule

// File: rtl/reg_bank_unit.sv
// ----------------------------------------------------------------------------
// reg_bank_unit
// NREGS x WIDTH register file with one nibble-masked write port, two
// combinational read ports, a serial nibble loader and a registered OUT port.
// Ports:
//   ck, rst                      clock, synchronous active-high reset
//   mem_data/in_data/alu_res     write-port data sources
//   alu_n                        sign bit used for the sign-fill source
//   wr_en, wr_src, wr_addr       write-port control
//   lane_we                      per-nibble write mask for the port
//   rd_addr_a/b, rd_data_a/b     read ports (unmapped addresses read 0)
//   nib_start, nib_addr,
//   nib_data, nib_valid          serial loader input stream
//   nib_ready, nib_done          serial loader status
//   out_we, out_data             OUT port, loaded from read port A
// ----------------------------------------------------------------------------
module reg_bank_unit
    import reg_bank_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NREGS = 4,
    localparam int AW    = $clog2(NREGS),
    localparam int NNIB  = WIDTH / NIB_W
) (
    input  logic              ck,
    input  logic              rst,
    input  logic [WIDTH-1:0]  mem_data,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [WIDTH-1:0]  alu_res,
    input  logic              alu_n,
    input  logic              wr_en,
    input  logic [1:0]        wr_src,
    input  logic [AW-1:0]     wr_addr,
    input  logic [NNIB-1:0]   lane_we,
    input  logic [AW-1:0]     rd_addr_a,
    input  logic [AW-1:0]     rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic [WIDTH-1:0]  rd_data_b,
    input  logic              nib_start,
    input  logic [AW-1:0]     nib_addr,
    input  logic [NIB_W-1:0]  nib_data,
    input  logic              nib_valid,
    output logic              nib_ready,
    output logic              nib_done,
    input  logic              out_we,
    output logic [WIDTH-1:0]  out_data
);

    logic [NREGS-1:0][WIDTH-1:0] w_regs;
    logic [WIDTH-1:0]            w_wdata;
    logic [WIDTH-1:0]            w_rd_a;
    logic [WIDTH-1:0]            w_rd_b;
    logic [AW-1:0]               w_ldr_addr;
    logic [NNIB-1:0]             w_ldr_lane;
    logic [WIDTH-1:0]            w_ldr_data;
    logic [WIDTH-1:0]            r_out;

    // Write-port source select
    always_comb begin
        w_wdata = '0;
        case (src_e'(wr_src))
            SRC_MEM:  w_wdata = mem_data;
            SRC_IN:   w_wdata = in_data;
            SRC_ALU:  w_wdata = alu_res;
            SRC_SIGN: w_wdata = {WIDTH{alu_n}};
            default:  w_wdata = '0;
        endcase
    end

    nib_loader #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_ldr (
        .ck          (ck),
        .rst         (rst),
        .i_start     (nib_start),
        .i_addr      (nib_addr),
        .i_data      (nib_data),
        .i_valid     (nib_valid),
        .o_ready     (nib_ready),
        .o_done      (nib_done),
        .o_tgt_addr  (w_ldr_addr),
        .o_lane_we   (w_ldr_lane),
        .o_lane_data (w_ldr_data)
    );

    // Register array, one nibble cell per (register, lane). Addresses that do
    // not map to a register never compare equal, so such writes fall away.
    // On a collision the port owns its masked lanes; the beat only lands in a
    // lane the port is not writing.
    for (genvar r = 0; r < NREGS; r++) begin : g_reg
        for (genvar k = 0; k < NNIB; k++) begin : g_nib
            logic [NIB_W-1:0] r_nib;
            logic             w_port_hit;
            logic             w_beat_hit;

            assign w_port_hit = wr_en & (wr_addr == AW'(r)) & lane_we[k];
            assign w_beat_hit = (w_ldr_addr == AW'(r)) & w_ldr_lane[k];

            always_ff @(posedge ck) begin
                if (rst)             r_nib <= '0;
                else if (w_port_hit) r_nib <= w_wdata[k*NIB_W +: NIB_W];
                else if (w_beat_hit) r_nib <= w_ldr_data[k*NIB_W +: NIB_W];
            end

            assign w_regs[r][k*NIB_W +: NIB_W] = r_nib;
        end
    end

    // Read ports: stored state only, no write-through.
    always_comb begin
        w_rd_a = '0;
        w_rd_b = '0;
        for (int r = 0; r < NREGS; r++) begin
            if (rd_addr_a == AW'(r)) w_rd_a = w_regs[r];
            if (rd_addr_b == AW'(r)) w_rd_b = w_regs[r];
        end
    end

    assign rd_data_a = w_rd_a;
    assign rd_data_b = w_rd_b;

    // OUT captures pre-edge read-port A contents.
    always_ff @(posedge ck) begin
        if (rst)         r_out <= '0;
        else if (out_we) r_out <= w_rd_a;
    end

    assign out_data = r_out;

endmodule

// File: tb/tb_reg_bank_unit.sv
module tb_reg_bank_unit;

    logic        ck = 1'b0;
    logic        rst;
    logic [15:0] mem_data, in_data, alu_res;
    logic        alu_n, wr_en;
    logic [1:0]  wr_src, wr_addr, rd_addr_a, rd_addr_b, nib_addr;
    logic [3:0]  lane_we, nib_data;
    logic        nib_start, nib_valid, out_we;

    logic [7:0]  rda8, rdb8, out8;
    logic        rdy8, done8;
    logic [15:0] rda16, rdb16, out16;
    logic        rdy16, done16;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        int          kind;   // 0: reg of 8-bit DUT, 1: reg of 16-bit DUT, 2: out8, 3: out16
        logic [1:0]  addr;
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];

    always #20 ck = ~ck;

    reg_bank_unit #(.WIDTH(8), .NREGS(4)) u8 (
        .ck(ck), .rst(rst),
        .mem_data(mem_data[7:0]), .in_data(in_data[7:0]), .alu_res(alu_res[7:0]),
        .alu_n(alu_n), .wr_en(wr_en), .wr_src(wr_src), .wr_addr(wr_addr),
        .lane_we(lane_we[1:0]),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rda8), .rd_data_b(rdb8),
        .nib_start(nib_start), .nib_addr(nib_addr), .nib_data(nib_data),
        .nib_valid(nib_valid), .nib_ready(rdy8), .nib_done(done8),
        .out_we(out_we), .out_data(out8)
    );

    reg_bank_unit #(.WIDTH(16), .NREGS(4)) u16 (
        .ck(ck), .rst(rst),
        .mem_data(mem_data), .in_data(in_data), .alu_res(alu_res),
        .alu_n(alu_n), .wr_en(wr_en), .wr_src(wr_src), .wr_addr(wr_addr),
        .lane_we(lane_we),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rda16), .rd_data_b(rdb16),
        .nib_start(nib_start), .nib_addr(nib_addr), .nib_data(nib_data),
        .nib_valid(nib_valid), .nib_ready(rdy16), .nib_done(done16),
        .out_we(out_we), .out_data(out16)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int kind, input logic [1:0] addr, input logic [15:0] exp);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.addr = addr;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    // Pop every pending expectation and compare against the DUT's view.
    task automatic drain();
        exp_t        e;
        logic [15:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_addr_b = e.addr;
            #1;
            case (e.kind)
                0:       obs = 16'(rdb8);
                1:       obs = rdb16;
                2:       obs = 16'(out8);
                default: obs = out16;
            endcase
            chk(e.tag, obs, e.exp);
        end
    endtask

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; mem_data = '0; in_data = '0; alu_res = '0; alu_n = 1'b0;
        wr_en = 1'b0; wr_src = 2'd0; wr_addr = 2'd0; lane_we = '0;
        rd_addr_a = 2'd0; rd_addr_b = 2'd0; nib_addr = 2'd0; nib_data = '0;
        nib_start = 1'b0; nib_valid = 1'b0; out_we = 1'b0;

        // 1. reset
        step(); step();
        rst = 1'b0;
        for (int a = 0; a < 4; a++) begin
            push("rst_r8", 0, 2'(a), 16'h0000);
            push("rst_r16", 1, 2'(a), 16'h0000);
        end
        push("rst_out8", 2, 2'd0, 16'h0000);
        push("rst_out16", 3, 2'd0, 16'h0000);
        drain();
        chk("rst_rdy8", 16'(rdy8), 16'd0);
        chk("rst_rdy16", 16'(rdy16), 16'd0);
        chk("rst_done8", 16'(done8), 16'd0);

        // 2. sources and lanes
        wr_en = 1'b1; wr_src = 2'd0; wr_addr = 2'd1; mem_data = 16'h00A5; lane_we = 4'b0011;
        step(); push("mem_r1", 0, 2'd1, 16'h00A5); drain();
        wr_src = 2'd1; in_data = 16'h003C; lane_we = 4'b0001;
        rd_addr_b = 2'd1; #1;
        chk("no_wthru", 16'(rdb8), 16'h00A5);
        step(); push("in_r1", 0, 2'd1, 16'h00AC); drain();
        wr_src = 2'd3; alu_n = 1'b1; lane_we = 4'b0010;
        step(); push("sign_r1", 0, 2'd1, 16'h00FC); drain();
        wr_src = 2'd0; mem_data = '0; lane_we = 4'b0000;
        step(); push("nolane_r1", 0, 2'd1, 16'h00FC); drain();
        wr_addr = 2'd0; wr_src = 2'd2; alu_res = 16'h005A; lane_we = 4'b0011;
        step(); push("alu_r0", 0, 2'd0, 16'h005A); drain();
        wr_src = 2'd3; alu_n = 1'b0; lane_we = 4'b0010;
        step(); push("sign0_r0", 0, 2'd0, 16'h000A); drain();
        wr_en = 1'b0; lane_we = '0;

        // 3. serial load with a gap
        nib_start = 1'b1; nib_addr = 2'd2;
        step(); nib_start = 1'b0;
        chk("ld_rdy", 16'(rdy8), 16'd1);
        nib_valid = 1'b1; nib_data = 4'h7;
        step(); nib_valid = 1'b0;
        push("beat0_r2", 0, 2'd2, 16'h0007); drain();
        step();
        chk("gap_rdy", 16'(rdy8), 16'd1);
        chk("gap_done", 16'(done8), 16'd0);
        nib_valid = 1'b1; nib_data = 4'h4;
        step(); nib_valid = 1'b0;
        chk("ld_done", 16'(done8), 16'd1);
        chk("done_rdy", 16'(rdy8), 16'd0);
        step();
        chk("done_1cyc", 16'(done8), 16'd0);
        chk("idle_rdy", 16'(rdy8), 16'd0);
        push("ser_r2", 0, 2'd2, 16'h0047); drain();

        // 4. collision between port and beat
        nib_start = 1'b1; nib_addr = 2'd3;
        step(); nib_start = 1'b0;
        nib_valid = 1'b1; nib_data = 4'h9;
        wr_en = 1'b1; wr_src = 2'd2; wr_addr = 2'd3; alu_res = 16'h0015; lane_we = 4'b0001;
        step(); wr_en = 1'b0; lane_we = '0;
        push("coll_r3", 0, 2'd3, 16'h0005); drain();
        nib_data = 4'h2;
        step(); nib_valid = 1'b0;
        chk("coll_done", 16'(done8), 16'd1);
        push("coll_r3b", 0, 2'd3, 16'h0025); drain();
        step();

        // 5. reset mid-load, then a clean load ignoring a stray start
        nib_start = 1'b1; nib_addr = 2'd0;
        step(); nib_start = 1'b0;
        nib_valid = 1'b1; nib_data = 4'hC;
        step(); nib_valid = 1'b0;
        push("pre_rst_r0", 0, 2'd0, 16'h000C); drain();
        rst = 1'b1;
        step(); rst = 1'b0;
        chk("mid_rst_rdy", 16'(rdy8), 16'd0);
        chk("mid_rst_done", 16'(done8), 16'd0);
        push("mid_rst_r0", 0, 2'd0, 16'h0000);
        push("mid_rst_r1", 0, 2'd1, 16'h0000);
        drain();
        step();
        chk("rst_nodone", 16'(done8), 16'd0);
        nib_start = 1'b1; nib_addr = 2'd0;
        step();
        nib_valid = 1'b1; nib_data = 4'hD; nib_start = 1'b1; nib_addr = 2'd1;
        step(); nib_start = 1'b0;
        nib_data = 4'h6;
        step(); nib_valid = 1'b0;
        chk("ld2_done", 16'(done8), 16'd1);
        step();
        chk("ld2_done_off", 16'(done8), 16'd0);
        push("ld2_r0", 0, 2'd0, 16'h006D);
        push("ign_start_r1", 0, 2'd1, 16'h0000);
        drain();

        // 6. 16-bit load and OUT timing
        rst = 1'b1;
        step(); step(); rst = 1'b0;
        nib_start = 1'b1; nib_addr = 2'd2;
        step(); nib_start = 1'b0;
        nib_valid = 1'b1; nib_data = 4'hF;
        step(); nib_data = 4'hE;
        step();
        step();
        chk("w16_nodone", 16'(done16), 16'd0);
        nib_data = 4'hB; out_we = 1'b1; rd_addr_a = 2'd2;
        step(); nib_valid = 1'b0;
        chk("w16_done", 16'(done16), 16'd1);
        push("out_old", 3, 2'd0, 16'h0EEF);
        push("w16_r2", 1, 2'd2, 16'hBEEF);
        drain();
        step();
        push("out_new", 3, 2'd0, 16'hBEEF); drain();
        wr_en = 1'b1; wr_src = 2'd0; wr_addr = 2'd2; mem_data = 16'h1234; lane_we = 4'b1111;
        step(); wr_en = 1'b0; out_we = 1'b0; lane_we = '0;
        push("out_wr_old", 3, 2'd0, 16'hBEEF);
        push("w16_r2_wr", 1, 2'd2, 16'h1234);
        drain();
        step();
        push("out_hold", 3, 2'd0, 16'hBEEF); drain();
        chk("rda16", rda16, 16'h1234);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
